matrix_row_comp: RTL and testbench
==================================

Name: matrix_row_comp

Overview:
Registered 4-lane fixed-point dot-product unit: result = a0·b0 + a1·b1 + a2·b2 + a3·b3.
Each operand is a packed 128-bit row or column of four 32-bit signed fixed-point elements.
It is the arithmetic core of the matrix/vertex multiplier in the transform pipeline. The parent uses it for both 4x4·4x4 and 4x4·4x1 (w lane zeroed by the parent) products.

Parameters:
FRAC_BITS, 16, number of fractional bits in every element (default signed Q16.16).
SATURATE, 1, 1 = clamp the result to signed 32-bit range; 0 = wrap (keep the low 32 bits).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
in_valid  input  1  a and b are valid this cycle
a  input  128  matrix row; element 0 in [127:96], element 1 in [95:64], element 2 in [63:32], element 3 in [31:0]
b  input  128  matrix column or vector; same lane packing as a
result  output  32  signed fixed-point dot product
out_valid  output  1  result is valid this cycle
overflow  output  1  saturation or wrap occurred for this result

Behaviour:
- Reset (reset=0, asynchronous): result=0, out_valid=0, overflow=0. Reset is released synchronously to clk by the surrounding system.
- Per lane i, the product p_i = signed(a_i) × signed(b_i) is a full-precision 64-bit value.
- Sum: s = p0+p1+p2+p3 in 66-bit signed arithmetic, so no intermediate overflow is possible.
- Scaling: q = s >>> FRAC_BITS (arithmetic shift, truncation toward −infinity, no rounding).
- Output conversion when SATURATE=1:
  - q > 0x7FFFFFFF → 0x7FFFFFFF, overflow=1.
  - q < −0x80000000 → 0x80000000, overflow=1.
  - Otherwise result = q[31:0], overflow=0.
- Output conversion when SATURATE=0: result = q[31:0]; overflow=1 iff q is outside the signed 32-bit range.
- Latency: exactly 1 cycle. On the clock edge where in_valid=1, result, overflow and out_valid=1 are registered.
- When in_valid=0: out_valid<=0, and result and overflow hold their last values.
- Throughput: one dot product per cycle. Back-to-back in_valid inputs give back-to-back out_valid outputs with no bubbles.
- No backpressure. The consumer must take result on the cycle out_valid=1.
- Zero lanes: a lane with a_i=0 or b_i=0 contributes exactly 0. The parent relies on this for 3-component vectors (b lane 3 = 0).
- Reset mid-operation: an in-flight result is discarded. out_valid=0 from the reset assertion until the first in_valid after release.
- Inputs carrying X while in_valid=0 must not propagate into result.

Decomposition:
- Shared package: ELEM_W=32, LANES=4, ROW_W=128, default FRAC_BITS, and a lane-extract function returning element i with element 0 at the MSBs.
- One natural sub-module: fxp_mul_lane (signed 32×32→64 multiply), instantiated four times.
- The adder tree, shift and saturation stay in matrix_row_comp.

Test Plan:
- Identity-style: a={1.0,2.0,3.0,4.0}={00010000,00020000,00030000,00040000}, b=all 00010000, in_valid=1 → next cycle result=000A0000, out_valid=1, overflow=0.
- Vector with w=0: a={00010000,00010000,00010000,00010000}, b={00020000,00030000,00040000,00000000} → 00090000.
- Signed/fractional: a={FFFF0000(−1.0),00008000(0.5),0,0}, b={00020000,00010000,0,0} → FFFE8000 (−1.5); a={00000001,0,0,0}, b={FFFFFFFF,0,0,0} → FFFFFFFF (truncation toward −inf).
- Saturation: a=b=all 7FFF0000 → 7FFFFFFF, overflow=1; a all 7FFF0000 with b all 80000000 → 80000000, overflow=1.
- Streaming and hold: 4 consecutive in_valid vectors → 4 consecutive out_valid results in order. Then in_valid=0 → out_valid=0 and result unchanged.
- Reset: assert reset=0 asynchronously between clock edges during streaming → result=0 and out_valid=0 immediately. After release, no out_valid until a new in_valid.

Source files
------------

// File: rtl/matrix_row_comp_pkg.sv
// Shared sizes and lane helpers for the 4-lane fixed-point dot-product unit.
package matrix_row_comp_pkg;
  localparam int ELEM_W        = 32;
  localparam int LANES         = 4;
  localparam int ROW_W         = ELEM_W * LANES;
  localparam int PROD_W        = 2 * ELEM_W;
  localparam int SUM_W         = PROD_W + 2;
  localparam int FRAC_BITS_DEF = 16;

  // Element 0 lives in the most significant lane.
  function automatic logic [ELEM_W-1:0] lane_elem(input logic [ROW_W-1:0] row, input int i);
    return row[ROW_W-1-i*ELEM_W -: ELEM_W];
  endfunction
endpackage

// File: rtl/matrix_row_comp_fxp_mul_lane.sv
// One lane of the dot product: full-precision signed 32x32 -> 64 multiply.
module fxp_mul_lane
  import matrix_row_comp_pkg::*;
(
  input  logic signed [ELEM_W-1:0] a,
  input  logic signed [ELEM_W-1:0] b,
  output logic signed [PROD_W-1:0] p
);
  logic signed [PROD_W-1:0] ax, bx;

  assign ax = {{ELEM_W{a[ELEM_W-1]}}, a};
  assign bx = {{ELEM_W{b[ELEM_W-1]}}, b};
  // Low PROD_W bits of the widened product are exact for 32x32 signed.
  assign p  = ax * bx;
endmodule

// File: rtl/matrix_row_comp.sv
// Registered 4-lane fixed-point dot product with saturating or wrapping output.
module matrix_row_comp
  import matrix_row_comp_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter bit SATURATE  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ROW_W-1:0]  a,
  input  logic [ROW_W-1:0]  b,
  output logic [ELEM_W-1:0] result,
  output logic              out_valid,
  output logic              overflow
);
  logic [LANES-1:0][ELEM_W-1:0] a_l, b_l;
  logic [LANES-1:0][PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]      sum, q;
  logic                         in_range;
  logic [ELEM_W-1:0]            res_n;
  logic                         ov_n;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign a_l[i] = lane_elem(a, i);
      assign b_l[i] = lane_elem(b, i);
      fxp_mul_lane u_mul (.a(a_l[i]), .b(b_l[i]), .p(prod[i]));
    end
  endgenerate

  // Two guard bits make the four-term sum overflow-free.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++)
      sum = sum + {{(SUM_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
  end

  assign q        = sum >>> FRAC_BITS;
  assign in_range = (q[SUM_W-1:ELEM_W-1] == {(SUM_W-ELEM_W+1){q[SUM_W-1]}});

  always_comb begin
    res_n = q[ELEM_W-1:0];
    ov_n  = ~in_range;
    if (SATURATE && !in_range)
      res_n = q[SUM_W-1] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
  end

  // result/overflow only load on in_valid, so idle-cycle X never reaches them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result    <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= res_n;
        overflow <= ov_n;
      end
    end
  end
endmodule

// File: tb/tb_matrix_row_comp.sv
// Scoreboard bench for matrix_row_comp: directed vectors, monitor pops on out_valid.
module tb_matrix_row_comp;
  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [127:0] a, b;
  logic [31:0]  result;
  logic         out_valid, overflow;

  typedef struct packed {
    logic [31:0] r;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  bit   pend   = 1'b0;

  matrix_row_comp dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
    .result(result), .out_valid(out_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] row(input logic [31:0] e0, e1, e2, e3);
    return {e0, e1, e2, e3};
  endfunction

  // Each issue also checks that the previous issue produced out_valid one cycle later.
  task automatic issue(input logic [127:0] va, vb, input logic [31:0] er, input logic eov);
    exp_t e;
    @(negedge clk);
    if (pend) chk("latency_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1;
    a = va;
    b = vb;
    e.r = er;
    e.ov = eov;
    sb.push_back(e);
    pend = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    if (pend) chk("latency_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    a = 'x;
    b = 'x;
    pend = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
      end
    end
  end

  localparam logic [31:0] ONE = 32'h0001_0000;

  initial begin
    logic [31:0] last;
    reset = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    #1;
    chk("reset_result", result, 32'd0);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single-shot vectors, each followed by an idle cycle.
    issue(row(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000),
          row(ONE, ONE, ONE, ONE), 32'h000A_0000, 1'b0);
    idle();
    issue(row(ONE, ONE, ONE, ONE),
          row(32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0), 32'h0009_0000, 1'b0);
    idle();
    issue(row(32'hFFFF_0000, 32'h0000_8000, 32'h0, 32'h0),
          row(32'h0002_0000, ONE, 32'h0, 32'h0), 32'hFFFE_8000, 1'b0);
    idle();
    issue(row(32'h1, 32'h0, 32'h0, 32'h0),
          row(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0), 32'hFFFF_FFFF, 1'b0);
    idle();
    issue({4{32'h7FFF_0000}}, {4{32'h7FFF_0000}}, 32'h7FFF_FFFF, 1'b1);
    idle();
    issue({4{32'h7FFF_0000}}, {4{32'h8000_0000}}, 32'h8000_0000, 1'b1);
    idle();

    // Back-to-back streaming, then hold.
    issue(row(ONE, ONE, ONE, ONE), row(32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0),
          32'h0009_0000, 1'b0);
    issue({4{32'h7FFF_0000}}, {4{32'h7FFF_0000}}, 32'h7FFF_FFFF, 1'b1);
    issue(row(32'hFFFF_0000, 32'h0000_8000, 32'h0, 32'h0),
          row(32'h0002_0000, ONE, 32'h0, 32'h0), 32'hFFFE_8000, 1'b0);
    issue(row(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000),
          row(ONE, ONE, ONE, ONE), 32'h000A_0000, 1'b0);
    last = 32'h000A_0000;
    idle();
    @(negedge clk);
    chk("hold_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_result", result, last);
    chk("hold_overflow", {31'd0, overflow}, 32'd0);

    // Asynchronous reset between edges while a result is in flight.
    issue(row(ONE, ONE, ONE, ONE), row(ONE, ONE, ONE, ONE), 32'h0004_0000, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_reset_result", result, 32'd0);
    chk("async_reset_valid", {31'd0, out_valid}, 32'd0);
    sb.delete();
    pend = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_valid", {31'd0, out_valid}, 32'd0);
    end
    issue(row(32'h0002_0000, 32'h0, 32'h0, 32'h0), row(32'h0003_0000, 32'h0, 32'h0, 32'h0),
          32'h0006_0000, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
